sat_trunc_fp: RTL and testbench

SAT_TRUNC_FP -- requirements
Module: sat_trunc_fp

---
 rtl/sat_trunc_fp_pkg.sv | 41 ++++
 rtl/sat_trunc_fp.sv | 72 +++++++
 tb/tb_sat_trunc_fp.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sat_trunc_fp_pkg.sv
// Default Q-format widths and a pure shift/round/saturate function shared with benches.
package sat_trunc_fp_pkg;

    localparam int SAT_NB_XI  = 20;
    localparam int SAT_NBF_XI = 12;
    localparam int SAT_NB_XO  = 8;
    localparam int SAT_NBF_XO = 7;

    typedef struct packed {
        logic        sat;
        logic [63:0] val;
    } sat_res_t;

    // x carries the raw nb_xi-bit pattern in its low bits; sign extension is done here.
    function automatic sat_res_t sat_trunc(input longint x, input int nb_xi, input int nbf_xi,
                                           input int nb_xo, input int nbf_xo, input int round);
        sat_res_t res;
        longint   v;
        longint   s;
        longint   hi;
        longint   lo;
        int       d;
        v  = x <<< (64 - nb_xi);
        v  = v >>> (64 - nb_xi);
        d  = nbf_xi - nbf_xo;
        if (round != 0 && d > 0)
            v = v + (longint'(1) <<< (d - 1));
        s  = v >>> d;
        hi = (longint'(1) <<< (nb_xo - 1)) - 1;
        lo = -hi - 1;
        res.sat = (s > hi) || (s < lo);
        if (s > hi)
            res.val = hi;
        else if (s < lo)
            res.val = lo;
        else
            res.val = s;
        return res;
    endfunction

endpackage

// File: rtl/sat_trunc_fp.sv
// Fixed-point requantiser: shift by NBF_XI-NBF_XO, optional round-half-up, saturate; 1-cycle registered.
// No backpressure: a new sample is taken on every edge with i_en=1, outputs hold while i_en=0.
module sat_trunc_fp
    import sat_trunc_fp_pkg::*;
#(
    parameter int NB_XI  = SAT_NB_XI,
    parameter int NBF_XI = SAT_NBF_XI,
    parameter int NB_XO  = SAT_NB_XO,
    parameter int NBF_XO = SAT_NBF_XO,
    parameter int ROUND  = 0
) (
    input  logic              clk,
    input  logic              i_srst,
    input  logic              i_en,
    input  logic [NB_XI-1:0]  i_data,
    output logic [NB_XO-1:0]  o_data,
    output logic              o_sat
);

    localparam int D   = NBF_XI - NBF_XO;
    localparam int NBS = NB_XI + 1 - D;

    if (NBF_XO > NBF_XI || (NB_XO - NBF_XO) > (NB_XI - NBF_XI) || NB_XO < 2) begin : g_bad_params
        $error("sat_trunc_fp: unsupported width combination");
    end

    localparam logic [NB_XI:0] HALF = (NB_XI+1)'(1) << ((D > 0) ? D - 1 : 0);

    // One guard bit above the input so the rounding add cannot wrap.
    logic [NB_XI:0]        ext;
    logic [NB_XI:0]        rnd;
    logic [NBS-1:0]        s;
    logic [NBS-NB_XO:0]    upper;
    logic                  clip;
    logic [NB_XO-1:0]      nxt;

    assign ext = {i_data[NB_XI-1], i_data};

    if (ROUND != 0 && D > 0) begin : g_round
        assign rnd = ext + HALF;
    end else begin : g_trunc
        assign rnd = ext;
    end

    if (D > 0) begin : g_frac
        logic unused_frac;
        assign unused_frac = ^rnd[D-1:0];
    end

    assign s = rnd[NB_XI:D];

    // Discarded integer bits plus the new sign bit must all agree, else the value is out of range.
    assign upper = s[NBS-1:NB_XO-1];
    assign clip  = !((&upper) || !(|upper));

    always_comb begin
        nxt = s[NB_XO-1:0];
        if (clip)
            nxt = s[NBS-1] ? {1'b1, {(NB_XO-1){1'b0}}} : {1'b0, {(NB_XO-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (i_srst) begin
            o_data <= '0;
            o_sat  <= 1'b0;
        end else if (i_en) begin
            o_data <= nxt;
            o_sat  <= clip;
        end
    end

endmodule

// File: tb/tb_sat_trunc_fp.sv
// Bench for sat_trunc_fp: directed boundary cases plus randomized samples against an integer model.
module tb_sat_trunc_fp;
    import sat_trunc_fp_pkg::*;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        en = 1'b0;
    logic [19:0] din = '0;
    logic [7:0]  dout_t;
    logic        sat_t;
    logic [7:0]  dout_r;
    logic        sat_r;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sat_trunc_fp #(.ROUND(0)) dut_t (
        .clk(clk), .i_srst(srst), .i_en(en), .i_data(din), .o_data(dout_t), .o_sat(sat_t)
    );

    sat_trunc_fp #(.ROUND(1)) dut_r (
        .clk(clk), .i_srst(srst), .i_en(en), .i_data(din), .o_data(dout_r), .o_sat(sat_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Q(20,12) -> Q(8,7): divide by 32 with floor, optional +16 first, clamp to [-128,127].
    function automatic logic [8:0] ref_model(input logic [19:0] d, input bit rnd);
        int         x;
        int         q;
        logic       clipped;
        logic [7:0] v;
        x = d[19] ? int'(d) - (1 << 20) : int'(d);
        if (rnd)
            x = x + 16;
        q = x / 32;
        if (x < 0 && (x % 32) != 0)
            q = q - 1;
        clipped = (q > 127) || (q < -128);
        if (q > 127)
            q = 127;
        if (q < -128)
            q = -128;
        v = 8'(q);
        return {clipped, v};
    endfunction

    task automatic step(input logic [19:0] d, input logic e, input logic r);
        @(negedge clk);
        din  = d;
        en   = e;
        srst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [19:0] dirs [6];
        logic [8:0]  exp_t;
        logic [8:0]  exp_r;
        logic [8:0]  m;
        logic [7:0]  hold_t;
        logic [7:0]  pkg_v;
        sat_res_t    pr;

        step(20'h12345, 1'b1, 1'b1);
        step(20'h01000, 1'b1, 1'b1);
        chk("reset_data", {24'd0, dout_t}, 32'h0);
        chk("reset_sat", {31'd0, sat_t}, 32'h0);

        // Directed boundaries, ROUND=0 instance with literal expectations.
        step(20'h00FE0, 1'b1, 1'b0);
        chk("pos_max_in_range", {23'd0, sat_t, dout_t}, {23'd0, 1'b0, 8'h7F});
        step(20'h01000, 1'b1, 1'b0);
        chk("pos_overflow", {23'd0, sat_t, dout_t}, {23'd0, 1'b1, 8'h7F});
        step(20'hFF000, 1'b1, 1'b0);
        chk("neg_min_in_range", {23'd0, sat_t, dout_t}, {23'd0, 1'b0, 8'h80});
        step(20'hFEFE0, 1'b1, 1'b0);
        chk("neg_overflow", {23'd0, sat_t, dout_t}, {23'd0, 1'b1, 8'h80});
        step(20'h0003F, 1'b1, 1'b0);
        chk("trunc_pos", {23'd0, sat_t, dout_t}, {23'd0, 1'b0, 8'h01});
        chk("round_pos", {23'd0, sat_r, dout_r}, {23'd0, 1'b0, 8'h02});
        step(20'hFFFFF, 1'b1, 1'b0);
        chk("trunc_neg", {23'd0, sat_t, dout_t}, {23'd0, 1'b0, 8'hFF});
        chk("round_neg", {23'd0, sat_r, dout_r}, {23'd0, 1'b0, 8'h00});
        step(20'h00FF0, 1'b1, 1'b0);
        chk("round_overflow", {23'd0, sat_r, dout_r}, {23'd0, 1'b1, 8'h7F});
        chk("trunc_of_00ff0", {23'd0, sat_t, dout_t}, {23'd0, 1'b0, 8'h7F});

        // Enable low: output must stay at the last captured value while input moves.
        step(20'h0003F, 1'b1, 1'b0);
        hold_t = dout_t;
        chk("pre_hold", {24'd0, hold_t}, 32'h01);
        dirs = '{20'h01000, 20'hFEFE0, 20'h00400, 20'hFFFFF, 20'h7FFFF, 20'h80000};
        foreach (dirs[i]) begin
            step(dirs[i], 1'b0, 1'b0);
            chk("hold_data", {24'd0, dout_t}, {24'd0, 8'h01});
            chk("hold_sat", {31'd0, sat_t}, 32'h0);
        end

        // Reset wins over enable and drops the sample on that edge.
        step(20'h01000, 1'b1, 1'b1);
        chk("srst_over_en", {23'd0, sat_t, dout_t}, 32'h0);
        chk("srst_over_en_r", {23'd0, sat_r, dout_r}, 32'h0);
        step(20'hFEFE0, 1'b1, 1'b0);
        chk("resume_after_srst", {23'd0, sat_t, dout_t}, {23'd0, 1'b1, 8'h80});

        // Full-scale extremes.
        step(20'h7FFFF, 1'b1, 1'b0);
        chk("full_pos", {23'd0, sat_t, dout_t}, {23'd0, 1'b1, 8'h7F});
        chk("full_pos_r", {23'd0, sat_r, dout_r}, {23'd0, 1'b1, 8'h7F});
        step(20'h80000, 1'b1, 1'b0);
        chk("full_neg", {23'd0, sat_t, dout_t}, {23'd0, 1'b1, 8'h80});
        chk("full_neg_r", {23'd0, sat_r, dout_r}, {23'd0, 1'b1, 8'h80});

        exp_t = {sat_t, dout_t};
        exp_r = {sat_r, dout_r};
        exp_t = ref_model(20'h80000, 1'b0);
        exp_r = ref_model(20'h80000, 1'b1);

        // Random samples, about 10% with enable low, biased toward the clip boundaries.
        for (int n = 0; n < 20000; n++) begin
            logic [19:0] d;
            logic        e;
            case ($urandom_range(3))
                0: d = 20'($urandom);
                1: d = 20'($urandom_range(32'h01100, 32'h00F00));
                2: d = 20'(32'h100000 - $urandom_range(32'h01100, 32'h00F00));
                default: d = 20'($urandom_range(32'h1F, 0)) ^ {20{$urandom_range(1)}};
            endcase
            e = ($urandom_range(9) != 0);
            step(d, e, 1'b0);
            if (e) begin
                exp_t = ref_model(d, 1'b0);
                exp_r = ref_model(d, 1'b1);
            end
            chk("rand_trunc", {23'd0, sat_t, dout_t}, {23'd0, exp_t});
            chk("rand_round", {23'd0, sat_r, dout_r}, {23'd0, exp_r});
            if (n % 8 == 0) begin
                m     = ref_model(d, 1'b0);
                pr    = sat_trunc(longint'(d), 20, 12, 8, 7, 0);
                pkg_v = pr.val[7:0];
                chk("pkg_func", {23'd0, pr.sat, pkg_v}, {23'd0, m});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
